// File: rtl/traffic_request_latch.sv
// traffic_request_latch: conditions the raw vehicle detectors and pedestrian
// buttons and latches them into per-road service requests (SA/SB). Each request
// is held until the controller shows that road GREEN (light code 2'b10).
// Optional feature macro: TL_PED_BUTTON_EN. When it is defined, the pedestrian
// buttons get their own synchroniser and debouncer channels. When it is
// undefined, the button ports are present but ignored.

// One input channel: a 2-flop synchroniser followed by a counting debouncer.
// rise_o pulses for one cycle after db_o goes 0->1.
module traffic_request_latch_chan #(
    parameter int DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);
    localparam logic [3:0] CNT_LAST = 4'(DB_CYCLES - 1);

    logic       s1_q, s2_q;
    logic       db_q, db_d;
    logic       db_prev_q;
    logic [3:0] cnt_q, cnt_d;

    // Accept a new level only after it has disagreed with db for DB_CYCLES cycles
    always_comb begin
        db_d  = db_q;
        cnt_d = 4'd0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = s2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Synchroniser, debouncer state and previous-level flop for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = db_q & ~db_prev_q;
endmodule

module traffic_request_latch #(
    parameter int DB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       DET_A,
    input  logic       DET_B,
    input  logic       BTN_PA,
    input  logic       BTN_PB,
    input  logic [1:0] A_LIGHT,
    input  logic [1:0] B_LIGHT,
    output logic       SA,
    output logic       SB
);
    localparam logic [1:0] LIGHT_GREEN = 2'b10;

    // Channel order: 0 DET_A, 1 DET_B, then 2 BTN_PA, 3 BTN_PB when buttons exist
`ifdef TL_PED_BUTTON_EN
    localparam int NUM_CH = 4;
    logic [NUM_CH-1:0] raw;
    assign raw = {BTN_PB, BTN_PA, DET_B, DET_A};
`else
    localparam int NUM_CH = 2;
    logic [NUM_CH-1:0] raw;
    logic              unused_btn;
    assign raw        = {DET_B, DET_A};
    assign unused_btn = BTN_PA ^ BTN_PB;
`endif

    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise;
    logic              set_a, set_b;
    logic              req_a_q, req_a_d;
    logic              req_b_q, req_b_d;
    logic              unused_rise;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            traffic_request_latch_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
                .CLK    (CLK),
                .RST_N  (RST_N),
                .raw_i  (raw[g]),
                .db_o   (db[g]),
                .rise_o (rise[g])
            );
        end
    endgenerate

    // Detector edges are never used; detectors request on level so a waiting
    // car re-requests as soon as its road leaves GREEN.
    assign unused_rise = ^rise[1:0];

    // BTN_PB crosses road B, so it is served while A is GREEN and requests A
`ifdef TL_PED_BUTTON_EN
    assign set_a = db[0] | rise[3];
    assign set_b = db[1] | rise[2];
`else
    assign set_a = db[0];
    assign set_b = db[1];
`endif

    // Request latches: GREEN clears and beats any set on the same edge
    always_comb begin
        req_a_d = req_a_q;
        req_b_d = req_b_q;
        if (A_LIGHT == LIGHT_GREEN) req_a_d = 1'b0;
        else if (set_a)             req_a_d = 1'b1;
        if (B_LIGHT == LIGHT_GREEN) req_b_d = 1'b0;
        else if (set_b)             req_b_d = 1'b1;
    end

    // Registered request outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_a_q <= 1'b0;
            req_b_q <= 1'b0;
        end else begin
            req_a_q <= req_a_d;
            req_b_q <= req_b_d;
        end
    end

    assign SA = req_a_q;
    assign SB = req_b_q;
endmodule

// File: tb/tb_traffic_request_latch.sv
// Bench for traffic_request_latch (DB_CYCLES = 4). Expectations are queued with
// the edge they apply to when a task schedules stimulus, and are popped and
// compared on the falling edge that follows that rising edge.
module tb_traffic_request_latch;
`ifdef TL_PED_BUTTON_EN
    localparam logic PED = 1'b1;
`else
    localparam logic PED = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       DET_A = 1'b0, DET_B = 1'b0, BTN_PA = 1'b0, BTN_PB = 1'b0;
    logic [1:0] A_LIGHT = 2'b00, B_LIGHT = 2'b10;
    logic       SA, SB;

    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned edge_n;
        bit          is_b;
        logic        val;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    traffic_request_latch #(.DB_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .DET_A(DET_A), .DET_B(DET_B),
        .BTN_PA(BTN_PA), .BTN_PB(BTN_PB), .A_LIGHT(A_LIGHT), .B_LIGHT(B_LIGHT),
        .SA(SA), .SB(SB)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Queue an expectation, keeping the queue ordered by edge
    task automatic expect_at(input int unsigned e, input bit is_b, input logic v, input string nm);
        exp_t x;
        int   i;
        x.edge_n = e; x.is_b = is_b; x.val = v; x.name = nm;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].edge_n > e) i--;
        sb_q.insert(i, x);
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        #2;
        checks++;
        if (SA !== 1'b0 || SB !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: SA=%b SB=%b, required 0 0", SA, SB);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (SA !== 1'b0 || SB !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: SA=%b SB=%b, required 0 0", SA, SB);
        end
    endtask

    task automatic test_basic();
        int unsigned b;
        exp_t e;
        logic got;
        A_LIGHT = 2'b00; B_LIGHT = 2'b10;
        b = edge_cnt;
        expect_at(b+6,  0, 1'b0, "basic_sa_before_latency");
        expect_at(b+7,  0, 1'b1, "basic_sa_set");
        expect_at(b+12, 0, 1'b1, "basic_sa_hold_after_release");
        expect_at(b+20, 0, 1'b1, "basic_sa_hold_long");
        expect_at(b+22, 0, 1'b0, "basic_sa_green_clear");
        expect_at(b+26, 0, 1'b0, "basic_sa_stays_clear");
        expect_at(b+26, 1, 1'b0, "basic_sb_idle");
        for (int c = 1; c <= 30; c++) begin
            case (c)
                1:  DET_A = 1'b1;
                10: DET_A = 1'b0;
                22: A_LIGHT = 2'b10;
                23: A_LIGHT = 2'b00;
                default: ;
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                e = sb_q.pop_front();
                got = e.is_b ? SB : SA;
                checks++;
                if (got !== e.val || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b, required %b at edge %0d", e.name, edge_cnt, got, e.val, e.edge_n);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int unsigned b;
        exp_t e;
        logic got;
        B_LIGHT = 2'b00;
        b = edge_cnt;
        expect_at(b+7,  1, 1'b0, "glitch3_sb_low");
        expect_at(b+10, 1, 1'b0, "glitch3_sb_still_low");
        expect_at(b+17, 1, 1'b0, "pulse5_sb_before_latency");
        expect_at(b+18, 1, 1'b1, "pulse5_sb_set");
        expect_at(b+30, 1, 1'b0, "pulse5_sb_green_clear");
        expect_at(b+34, 1, 1'b0, "pulse5_sb_stays_clear");
        for (int c = 1; c <= 36; c++) begin
            case (c)
                1:  DET_B = 1'b1;
                4:  DET_B = 1'b0;
                12: DET_B = 1'b1;
                17: DET_B = 1'b0;
                30: B_LIGHT = 2'b10;
                31: B_LIGHT = 2'b00;
                default: ;
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                e = sb_q.pop_front();
                got = e.is_b ? SB : SA;
                checks++;
                if (got !== e.val || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b, required %b at edge %0d", e.name, edge_cnt, got, e.val, e.edge_n);
                end
            end
        end
    endtask

    task automatic test_button();
        int unsigned b;
        exp_t e;
        logic got;
        A_LIGHT = 2'b00; B_LIGHT = 2'b00;
        b = edge_cnt;
        expect_at(b+6,  1, 1'b0, "btn_pa_sb_before_latency");
        expect_at(b+7,  1, PED,  "btn_pa_sb_set");
        expect_at(b+16, 1, PED,  "btn_pa_sb_hold_after_release");
        expect_at(b+16, 0, 1'b0, "btn_pa_sa_untouched");
        expect_at(b+18, 1, 1'b0, "btn_pa_sb_green_clear");
        expect_at(b+26, 1, 1'b0, "btn_pa_during_green_dropped");
        expect_at(b+27, 1, 1'b0, "btn_pa_during_green_dropped2");
        expect_at(b+35, 1, 1'b0, "btn_pa_not_reasserted");
        expect_at(b+40, 1, 1'b0, "btn_pa_not_reasserted2");
        expect_at(b+47, 0, 1'b0, "btn_pb_sa_before_latency");
        expect_at(b+48, 0, PED,  "btn_pb_sa_set");
        expect_at(b+54, 0, 1'b0, "btn_pb_sa_green_clear");
        expect_at(b+56, 0, 1'b0, "btn_pb_sa_stays_clear");
        for (int c = 1; c <= 56; c++) begin
            case (c)
                1:  BTN_PA = 1'b1;
                9:  BTN_PA = 1'b0;
                18: B_LIGHT = 2'b10;
                20: BTN_PA = 1'b1;
                28: BTN_PA = 1'b0;
                35: B_LIGHT = 2'b00;
                42: BTN_PB = 1'b1;
                50: BTN_PB = 1'b0;
                54: A_LIGHT = 2'b10;
                55: A_LIGHT = 2'b00;
                default: ;
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                e = sb_q.pop_front();
                got = e.is_b ? SB : SA;
                checks++;
                if (got !== e.val || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b, required %b at edge %0d", e.name, edge_cnt, got, e.val, e.edge_n);
                end
            end
        end
    endtask

    task automatic test_set_clear();
        int unsigned b;
        exp_t e;
        logic got;
        A_LIGHT = 2'b10; B_LIGHT = 2'b00;
        b = edge_cnt;
        expect_at(b+7,  0, 1'b0, "setclr_sa_green_wins");
        expect_at(b+9,  0, 1'b0, "setclr_sa_green_wins2");
        expect_at(b+10, 0, 1'b1, "setclr_sa_after_yellow");
        expect_at(b+20, 0, 1'b1, "setclr_code11_no_clear");
        expect_at(b+22, 0, 1'b0, "setclr_sa_green_clear");
        expect_at(b+26, 0, 1'b0, "setclr_sa_stays_clear");
        for (int c = 1; c <= 26; c++) begin
            case (c)
                1:  DET_A = 1'b1;
                10: A_LIGHT = 2'b01;
                12: begin A_LIGHT = 2'b11; DET_A = 1'b0; end
                22: A_LIGHT = 2'b10;
                23: A_LIGHT = 2'b00;
                default: ;
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                e = sb_q.pop_front();
                got = e.is_b ? SB : SA;
                checks++;
                if (got !== e.val || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b, required %b at edge %0d", e.name, edge_cnt, got, e.val, e.edge_n);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned b;
        exp_t e;
        logic got;
        A_LIGHT = 2'b00; B_LIGHT = 2'b00;
        b = edge_cnt;
        expect_at(b+7,  1, 1'b1, "rstmid_sb_set");
        expect_at(b+14, 0, 1'b0, "rstmid_sa_in_reset");
        expect_at(b+14, 1, 1'b0, "rstmid_sb_in_reset");
        expect_at(b+21, 1, 1'b0, "rstmid_sb_before_latency");
        expect_at(b+22, 1, 1'b1, "rstmid_sb_set_after_reset");
        expect_at(b+22, 0, 1'b0, "rstmid_sa_abandoned");
        for (int c = 1; c <= 24; c++) begin
            case (c)
                1:  DET_B = 1'b1;
                8:  DET_A = 1'b1;
                12: begin
                    #1 RST_N = 1'b0;
                    #1;
                    checks++;
                    if (SA !== 1'b0 || SB !== 1'b0) begin
                        errors++;
                        $display("FAIL rstmid_async: SA=%b SB=%b, required 0 0", SA, SB);
                    end
                end
                13: DET_A = 1'b0;
                16: RST_N = 1'b1;
                default: ;
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                e = sb_q.pop_front();
                got = e.is_b ? SB : SA;
                checks++;
                if (got !== e.val || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b, required %b at edge %0d", e.name, edge_cnt, got, e.val, e.edge_n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_button();
        test_set_clear();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_request_latch.md
# traffic_request_latch

Upstream conditioning stage for the two-road traffic light controller. It synchronises and debounces raw vehicle-loop detectors and pedestrian push-buttons, then latches them into per-road service requests. It drives the controller's `SA`/`SB` demand inputs and holds each request until the controller shows that road GREEN. The controller's car-light codes are fed back as the acknowledge.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles needed to accept a new input level; legal range 2–15.
- `CLK  in  1`: single system clock; all state updates on the rising edge.
- `RST_N  in  1`: reset, asynchronous and active-low.
- `DET_A  in  1`: raw vehicle detector for road A; asynchronous; high means a car is present.
- `DET_B  in  1`: raw vehicle detector for road B; asynchronous.
- `BTN_PA  in  1`: raw pedestrian button for crossing road A (served while B is GREEN); asynchronous.
- `BTN_PB  in  1`: raw pedestrian button for crossing road B (served while A is GREEN); asynchronous.
- `A_LIGHT  in  2`: controller road-A car-light code (00 RED, 01 YELLOW, 10 GREEN, 11 BLINKING_RED).
- `B_LIGHT  in  2`: controller road-B car-light code.
- `SA  out  1`: road A service request, registered.
- `SB  out  1`: road B service request, registered.

## Operation
- There are four identical input channels: DET_A, DET_B, BTN_PA and BTN_PB.
- **Synchroniser:** each channel passes through a 2-flop synchroniser; the second stage is `s2`.
- **Debouncer:**
  - Each channel has a debounced level `db` and a 4-bit counter `cnt`.
  - If `s2 == db`, then `cnt <= 0`.
  - If `s2 != db` and `cnt == DB_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - Any disagreement shorter than DB_CYCLES cycles is discarded.
- **Request sources:**
  - `setA` = `db(DET_A)` level, OR a `db(BTN_PB)` rising edge.
  - `setB` = `db(DET_B)` level, OR a `db(BTN_PA)` rising edge.
  - A debounced rising edge is `db` going 0→1 on this clock edge.
- **Request latches:** `reqA` and `reqB` are flops that drive SA and SB directly.
  - If `A_LIGHT == 2'b10`, then `reqA <= 0`.
  - Otherwise, if `setA`, then `reqA <= 1`.
  - Otherwise `reqA` holds.
  - `reqB` follows the same rules using `B_LIGHT`.
- **Clear priority:** clear beats set on the same edge.
- **Presence during GREEN:**
  - A car still present when GREEN ends re-asserts its request on the first non-GREEN edge. This is intended, because the car is still waiting.
  - A button edge arriving while its served road is GREEN is dropped, since the pedestrian is being served.
- **Reset:** RST_N low forces all synchroniser flops, `db`, `cnt`, `reqA` and `reqB` to 0 immediately. SA = SB = 0.
  - A debounce in progress is abandoned.
  - After reset release, an input that is already high is accepted only after the full latency below.
- **Unknown codes:** light codes other than 10 never clear a request.

## Timing
- Let edge k be the first rising edge that samples a new raw level.
  - `s2` updates at k+1.
  - `db` updates at k+DB_CYCLES+1.
  - `reqX` (and so SA/SB) updates at k+DB_CYCLES+2.
  - With default DB_CYCLES=4, SA rises 6 edges after edge k.
- **Acknowledge:** if A_LIGHT becomes 10 before edge m, SA is low after edge m (1-cycle acknowledge).
- **Release:** a detector going low does not clear a request. Only a GREEN acknowledge clears it.
- **Minimum pulse:** an input accepted by the debouncer must be stable for at least DB_CYCLES+1 edges after synchronisation.
- **Combinational paths:** none from any input to any output.

## Configuration
- Macro: `TL_PED_BUTTON_EN`.
- **Defined:** BTN_PA and BTN_PB have full synchroniser and debouncer channels and contribute rising-edge requests as described above.
- **Undefined:**
  - Both button channels are removed from the logic; the BTN_PA and BTN_PB ports remain but are ignored.
  - `setA` = `db(DET_A)` and `setB` = `db(DET_B)` only.
  - The port list is identical in both builds.

## Test plan
- **Basic request/clear:** DB_CYCLES=4, A_LIGHT=00 and B_LIGHT=10, then DET_A driven high at edge 10 → SA=1 after edge 16. SA stays high after DET_A falls. A_LIGHT=10 set before edge 30 → SA=0 after edge 30.
- **Glitch rejection:** DET_B high for 3 cycles, then low, with B_LIGHT=00 → SB stays 0 throughout. Repeat with 5 cycles → SB=1.
- **Pedestrian button (macro defined):**
  - BTN_PA pulsed high for 8 cycles with B_LIGHT=00 → SB=1 6 edges after the press, and it remains 1 after release.
  - Same press with B_LIGHT=10 → SB stays 0.
  - Without the macro, the same press → SB=0.
- **Simultaneous set and clear:** DET_A high and debounced while A_LIGHT=10 → SA stays 0. A_LIGHT changes to 01 → SA=1 after the next edge.
- **Reset mid-operation:**
  - RST_N pulled low mid-debounce (cnt=2) and while SB=1 → SA=SB=0 immediately, without waiting for CLK.
  - After release with DET_B held high → SB rises 6 edges after the first post-reset edge.
